// File: rtl/anc_pkg.sv
// Shared types and width helpers for the ANC FIR multiply-accumulate filter.
package anc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } anc_state_t;

  localparam int DEF_DATA_W = 11;
  localparam int DEF_COEF_W = 11;
  localparam int DEF_TAPS   = 16;

  // Accumulator holds TAPS full-precision products without overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Width left once the COEF_W-1 fractional bits are shifted out.
  function automatic int rnd_width(input int data_w, input int coef_w, input int taps);
    return acc_width(data_w, coef_w, taps) - (coef_w - 1);
  endfunction

endpackage

// File: rtl/anc_mac_unit.sv
// Registered signed multiply-accumulate: one product per enabled cycle, clear has priority.
module anc_mac_unit
  import anc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_COEF_W, DEF_TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_p1;

  assign prod = PROD_W'(sample) * PROD_W'(coef);

  // Stage p1: accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
    end else if (clr) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= acc_p1 + ACC_W'(prod);
    end
  end

  assign acc = acc_p1;

endmodule

// File: rtl/anc_fir_mac.sv
// Time-multiplexed FIR for ANC: circular delay line, coefficient RAM, one MAC per clock,
// rounded and saturated result registered TAPS+1 clocks after each accepted sample strobe.
module anc_fir_mac
  import anc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS
) (
  input  logic                      Clk_100M,
  input  logic                      Reset_n,
  input  logic                      FilterEN,
  input  logic                      Synch,
  input  logic signed [DATA_W-1:0]  SigIn,
  input  logic                      CoefWr,
  input  logic [$clog2(TAPS)-1:0]   CoefAddr,
  input  logic signed [COEF_W-1:0]  Wz,
  input  logic                      ClrFlags,
  output logic signed [DATA_W-1:0]  FiltOut,
  output logic                      OutValid,
  output logic                      Busy,
  output logic                      Overrun
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int RND_W  = rnd_width(DATA_W, COEF_W, TAPS);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (COEF_W - 2);
  localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN  = -SAT_MAX - RND_W'(1);

  function automatic logic signed [RND_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] biased;
    biased = a + RND_HALF;
    return RND_W'(biased >>> (COEF_W - 1));
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [RND_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  anc_state_t state, state_nxt;

  logic                     synch_d;
  logic                     synch_edge;
  logic                     accept;
  logic                     busy;
  logic [ADDR_W-1:0]        head;
  logic [ADDR_W-1:0]        tap_cnt;
  logic [ADDR_W-1:0]        rd_idx;
  logic signed [DATA_W-1:0] dline [TAPS];
  logic signed [COEF_W-1:0] coef  [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] dout_p2;
  logic                     vld_p2;
  logic                     overrun;

  assign synch_edge = Synch & ~synch_d;
  assign busy       = (state != ST_IDLE);
  assign accept     = (state == ST_IDLE) & FilterEN & synch_edge;
  // Newest sample sits just behind head; tap k walks backwards through history.
  assign rd_idx     = head - ADDR_W'(1) - tap_cnt;

  always_comb begin
    state_nxt = state;
    if (!FilterEN) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (synch_edge) state_nxt = ST_MAC;
        ST_MAC:  if (tap_cnt == ADDR_W'(TAPS - 1)) state_nxt = ST_OUT;
        ST_OUT:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      synch_d <= 1'b1;
      head    <= '0;
      tap_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      synch_d <= Synch;
      if (accept) begin
        head    <= head + ADDR_W'(1);
        tap_cnt <= '0;
      end else if (state == ST_MAC) begin
        tap_cnt <= tap_cnt + ADDR_W'(1);
      end
      if (busy && synch_edge && FilterEN) begin
        overrun <= 1'b1;
      end else if (ClrFlags) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      if (accept) dline[head] <= SigIn;
      if (CoefWr && !busy) coef[CoefAddr] <= Wz;
    end
  end

  // Stage p1: accumulate one tap product per MAC cycle
  anc_mac_unit #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (Clk_100M),
    .rst_n (Reset_n),
    .clr   (accept | ~FilterEN),
    .en    ((state == ST_MAC) & FilterEN),
    .sample(dline[rd_idx]),
    .coef  (coef[tap_cnt]),
    .acc   (acc)
  );

  // Stage p2: round, saturate and register the result
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      dout_p2 <= '0;
      vld_p2  <= 1'b0;
    end else if (!FilterEN) begin
      dout_p2 <= '0;
      vld_p2  <= 1'b0;
    end else if (state == ST_OUT) begin
      dout_p2 <= saturate(round_acc(acc));
      vld_p2  <= 1'b1;
    end else begin
      vld_p2  <= 1'b0;
    end
  end

  assign FiltOut  = dout_p2;
  assign OutValid = vld_p2;
  assign Busy     = busy;
  assign Overrun  = overrun;

endmodule

// File: tb/tb_anc_fir_mac.sv
// Self-checking bench for anc_fir_mac: fixed vector tables, hand-written corner sequences
// and randomized samples/coefficients compared against a queue-based convolution model.
module tb_anc_fir_mac;

  localparam int DATA_W = 11;
  localparam int COEF_W = 11;
  localparam int TAPS   = 16;
  localparam int AW     = 4;
  localparam int Y_MAX  = (1 << (DATA_W - 1)) - 1;
  localparam int Y_MIN  = -(1 << (DATA_W - 1));

  logic                     Clk_100M = 1'b0;
  logic                     Reset_n;
  logic                     FilterEN;
  logic                     Synch;
  logic signed [DATA_W-1:0] SigIn;
  logic                     CoefWr;
  logic [AW-1:0]            CoefAddr;
  logic signed [COEF_W-1:0] Wz;
  logic                     ClrFlags;
  logic signed [DATA_W-1:0] FiltOut;
  logic                     OutValid;
  logic                     Busy;
  logic                     Overrun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int x;
    int y;
  } vec_t;

  vec_t imp_tbl [20];

  int m_hist[$];
  int m_coef [TAPS];

  anc_fir_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .TAPS  (TAPS)
  ) dut (
    .Clk_100M(Clk_100M),
    .Reset_n (Reset_n),
    .FilterEN(FilterEN),
    .Synch   (Synch),
    .SigIn   (SigIn),
    .CoefWr  (CoefWr),
    .CoefAddr(CoefAddr),
    .Wz      (Wz),
    .ClrFlags(ClrFlags),
    .FiltOut (FiltOut),
    .OutValid(OutValid),
    .Busy    (Busy),
    .Overrun (Overrun)
  );

  always #5 Clk_100M = ~Clk_100M;

  task automatic tick();
    @(posedge Clk_100M);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: y[n] = sat(round(sum_k x[n-k]*w[k] / 2^(COEF_W-1)))
  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < TAPS; i++) begin
      m_hist.push_back(0);
      m_coef[i] = 0;
    end
  endfunction

  function automatic int model_step(input int x);
    longint sum;
    longint r;
    sum = 0;
    m_hist.push_front(x);
    void'(m_hist.pop_back());
    for (int k = 0; k < TAPS; k++) sum += longint'(m_hist[k]) * longint'(m_coef[k]);
    r = (sum + (longint'(1) << (COEF_W - 2))) >>> (COEF_W - 1);
    if (r > Y_MAX) r = Y_MAX;
    if (r < Y_MIN) r = Y_MIN;
    return int'(r);
  endfunction

  task automatic do_reset();
    Reset_n  = 1'b0;
    FilterEN = 1'b1;
    Synch    = 1'b0;
    SigIn    = '0;
    CoefWr   = 1'b0;
    CoefAddr = '0;
    Wz       = '0;
    ClrFlags = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic write_coef(input int k, input int v);
    CoefWr   = 1'b1;
    CoefAddr = AW'(k);
    Wz       = COEF_W'(v);
    tick();
    CoefWr   = 1'b0;
    m_coef[k] = v;
  endtask

  // One full sample: strobe, optional coincident coefficient write, optional write while busy.
  task automatic run_sample(input string name, input int x, input bit cw, input int ca, input int cv,
                            input bit busy_wr, output int y);
    int lat;
    Synch = 1'b0;
    tick();
    Synch = 1'b1;
    SigIn = DATA_W'(x);
    if (cw) begin
      CoefWr     = 1'b1;
      CoefAddr   = AW'(ca);
      Wz         = COEF_W'(cv);
      m_coef[ca] = cv;
    end
    tick();
    Synch  = 1'b0;
    CoefWr = 1'b0;
    check({name, " busy"}, Busy, 1);
    lat = 0;
    while (OutValid !== 1'b1 && lat < 40) begin
      if (busy_wr && lat == 3) begin
        CoefWr   = 1'b1;
        CoefAddr = AW'($urandom_range(TAPS - 1));
        Wz       = COEF_W'($urandom);
      end else begin
        CoefWr = 1'b0;
      end
      tick();
      lat++;
    end
    CoefWr = 1'b0;
    check({name, " latency"}, lat, TAPS + 1);
    y = FiltOut;
    tick();
    check({name, " pulse"}, OutValid, 0);
  endtask

  initial begin
    int y, e, nv, x, ca, cv;
    bit cw, bw;

    imp_tbl[0] = '{200, 100};
    for (int i = 1; i < 4; i++)  imp_tbl[i] = '{0, 100};
    for (int i = 4; i < 20; i++) imp_tbl[i] = '{0, 0};

    do_reset();
    check("reset FiltOut", FiltOut, 0);
    check("reset OutValid", OutValid, 0);
    check("reset Busy", Busy, 0);
    check("reset Overrun", Overrun, 0);

    write_coef(0, 512);
    e = model_step(100);
    run_sample("single", 100, 1'b0, 0, 0, 1'b0, y);
    check("single value", y, 50);

    do_reset();
    for (int k = 0; k < 4; k++) write_coef(k, 512);
    for (int i = 0; i < 20; i++) begin
      e = model_step(imp_tbl[i].x);
      run_sample($sformatf("imp%0d", i), imp_tbl[i].x, 1'b0, 0, 0, 1'b0, y);
      check($sformatf("imp%0d value", i), y, imp_tbl[i].y);
    end

    for (int k = 0; k < TAPS; k++) write_coef(k, 1023);
    for (int i = 0; i < 16; i++) begin
      e = model_step(1023);
      run_sample($sformatf("satp%0d", i), 1023, 1'b0, 0, 0, 1'b0, y);
      check($sformatf("satp%0d value", i), y, e);
    end
    check("sat positive", y, 1023);
    for (int i = 0; i < 16; i++) begin
      e = model_step(-1024);
      run_sample($sformatf("satn%0d", i), -1024, 1'b0, 0, 0, 1'b0, y);
      check($sformatf("satn%0d value", i), y, e);
    end
    check("sat negative", y, -1024);

    do_reset();
    write_coef(0, 512);
    e = model_step(100);
    Synch = 1'b0; tick();
    Synch = 1'b1; SigIn = 11'sd100; tick();
    Synch = 1'b0; SigIn = 11'sd77;
    repeat (4) tick();
    Synch = 1'b1; tick();
    Synch = 1'b0;
    check("overrun flag", Overrun, 1);
    nv = 0; y = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (OutValid) begin nv++; y = FiltOut; end
    end
    check("overrun pulses", nv, 1);
    check("overrun value", y, 50);
    ClrFlags = 1'b1; tick(); ClrFlags = 1'b0;
    check("overrun clear", Overrun, 0);

    e = model_step(10);
    Synch = 1'b0; tick();
    Synch = 1'b1; SigIn = 11'sd10; tick();
    Synch = 1'b0; tick(); tick();
    Synch = 1'b1; ClrFlags = 1'b1; tick();
    Synch = 1'b0; ClrFlags = 1'b0;
    check("set wins over clear", Overrun, 1);
    nv = 0; y = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (OutValid) begin nv++; y = FiltOut; end
    end
    check("setwins pulses", nv, 1);
    check("setwins value", y, e);
    ClrFlags = 1'b1; tick(); ClrFlags = 1'b0;

    write_coef(1, 512);
    e = model_step(60);
    Synch = 1'b0; tick();
    Synch = 1'b1; SigIn = 11'sd60; tick();
    Synch = 1'b0;
    repeat (5) tick();
    FilterEN = 1'b0; tick();
    check("disable Busy", Busy, 0);
    check("disable FiltOut", FiltOut, 0);
    check("disable OutValid", OutValid, 0);
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (OutValid) nv++;
    end
    check("disable no pulse", nv, 0);
    FilterEN = 1'b1;
    e = model_step(30);
    run_sample("reenable", 30, 1'b0, 0, 0, 1'b0, y);
    check("reenable value", y, 45);
    check("reenable model", y, e);

    Synch = 1'b0; tick();
    Synch = 1'b1; SigIn = 11'sd50; tick();
    Synch = 1'b0;
    repeat (4) tick();
    Synch = 1'b1; Reset_n = 1'b0; tick(); tick();
    Reset_n = 1'b1;
    model_reset();
    tick();
    check("midrst FiltOut", FiltOut, 0);
    check("midrst OutValid", OutValid, 0);
    check("midrst Busy", Busy, 0);
    check("midrst Overrun", Overrun, 0);
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (Busy || OutValid) nv++;
    end
    check("midrst no accept", nv, 0);
    write_coef(0, 512);
    e = model_step(40);
    run_sample("post reset", 40, 1'b0, 0, 0, 1'b0, y);
    check("post reset value", y, 20);

    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(2047)) - 1024);
    for (int i = 0; i < 40; i++) begin
      x  = int'($urandom_range(2047)) - 1024;
      cw = ($urandom_range(3) == 0);
      ca = int'($urandom_range(TAPS - 1));
      cv = int'($urandom_range(2047)) - 1024;
      bw = ($urandom_range(2) == 0);
      run_sample($sformatf("rnd%0d", i), x, cw, ca, cv, bw, y);
      e = model_step(x);
      check($sformatf("rnd%0d value", i), y, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/anc_fir_mac.md
ANC_FIR_MAC -- requirements
Module: anc_fir_mac

Interface
REQ-001 Parameter DATA_W, 11, signed sample width of SigIn and FiltOut.
REQ-002 Parameter COEF_W, 11, signed coefficient width in Q1.(COEF_W-1) format.
REQ-003 Parameter TAPS, 16, filter length; power of two, 2..64.
REQ-004 Port Clk_100M  input  1  sole clock; all logic on rising edge.
REQ-005 Port Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port FilterEN  input  1  filter enable; low aborts work and clears output.
REQ-007 Port Synch  input  1  sample strobe, synchronous to Clk_100M; rising edge requests one sample.
REQ-008 Port SigIn  input  DATA_W  signed input sample, captured on the accepted Synch edge.
REQ-009 Port CoefWr  input  1  coefficient write strobe.
REQ-010 Port CoefAddr  input  clog2(TAPS)  coefficient index (tap k).
REQ-011 Port Wz  input  COEF_W  signed coefficient write data.
REQ-012 Port ClrFlags  input  1  clears sticky Overrun.
REQ-013 Port FiltOut  output  DATA_W  signed filtered sample, registered.
REQ-014 Port OutValid  output  1  one-cycle pulse when FiltOut updates.
REQ-015 Port Busy  output  1  high whenever FSM is not IDLE.
REQ-016 Port Overrun  output  1  sticky: Synch edge arrived while Busy.

Function
REQ-017 Synch edge = Synch high and registered Synch_d low at a clock edge.
REQ-018 FSM states IDLE, MAC, OUT; IDLE->MAC on Synch edge with FilterEN=1; MAC->OUT after TAPS MAC cycles; OUT->IDLE unconditionally.
REQ-019 On acceptance edge: SigIn written to circular delay line at head pointer, head advances modulo TAPS (wrap-around), accumulator cleared.
REQ-020 MAC cycle k (k=0..TAPS-1) adds x[n-k]*w[k] to accumulator; one multiply per cycle.
REQ-021 Accumulator width DATA_W+COEF_W+clog2(TAPS); no internal overflow possible.
REQ-022 Output = (acc + 2^(COEF_W-2)) arithmetic-shifted right by COEF_W-1, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-023 FiltOut and OutValid update at edge TAPS+1 after acceptance edge; OutValid high exactly one cycle; FiltOut holds until next result.
REQ-024 Synch edge while Busy: sample dropped, delay line untouched, Overrun set; ClrFlags clears it; simultaneous set and clear -> set wins.
REQ-025 Synch edge in OUT state is an overrun; edge on first IDLE cycle is accepted (min sample period TAPS+2 clocks).
REQ-026 FilterEN low: FSM to IDLE next edge, FiltOut forced 0, OutValid 0, no Synch accepted; delay line and coefficients retained.
REQ-027 CoefWr in IDLE writes Wz to w[CoefAddr] next edge; CoefWr while Busy ignored (no flag).
REQ-028 CoefWr coincident with accepted Synch edge: write performed, new coefficient used for that sample.

Reset
REQ-029 Reset_n low: FSM IDLE, FiltOut 0, OutValid 0, Busy 0, Overrun 0, head 0, delay line all 0, coefficients all 0, accumulator 0.
REQ-030 Synch_d resets to 1 so Synch held high through reset release yields no spurious edge.
REQ-031 Reset mid-MAC discards the computation; no OutValid issued.

Structure
REQ-032 Shared package anc_pkg holds FSM state enum, default DATA_W/COEF_W/TAPS, and saturate/round width constants.
REQ-033 One sub-module anc_mac_unit: registered signed multiply-accumulate with clear and enable; FSM, storage and rounding in top.

Verification (TAPS=16 unless stated)
REQ-034 Reset, w[0]=512, others 0, SigIn=100, one Synch edge -> OutValid at edge 17 after acceptance, FiltOut=50.
REQ-035 Impulse: w[0..3]=512, SigIn 200 then 0 for 19 more samples -> FiltOut 100,100,100,100 then 0 (delay-line wrap exercised).
REQ-036 Saturation: all w=1023, SigIn=1023 repeated 16 samples -> FiltOut 1023; SigIn=-1024 repeated 16 -> FiltOut -1024.
REQ-037 Overrun: second Synch edge 5 clocks after first -> Overrun=1, single OutValid, result equals single-sample case; ClrFlags -> Overrun=0.
REQ-038 FilterEN dropped mid-MAC -> Busy 0 next cycle, FiltOut 0, no OutValid; re-enable and Synch -> correct result from retained history.
REQ-039 Reset_n asserted mid-MAC with Synch held high through release -> all outputs 0, no acceptance until Synch toggles low then high.
